nanci_pe_xchg: RTL and testbench
================================

// Module: nanci_pe_xchg
// PURPOSE
//  Parametrised neighbour-exchange core for the Nanci mesh PE.
//  Executes queued commands against the four neighbour words (l/r/u/d): hold, select, min or max.
//  The commands are the sort-phase compare-exchange steps of the mesh.
//  Replaces the fixed single-cycle select path; adds repeat counts, a command handshake and row-edge masking.
// PARAMETERS
//  ADDR_WIDTH    3    address (sort key) field width, word MSBs
//  DATA_WIDTH    3    payload field width, word LSBs
//  CNT_WIDTH     4    width of command repeat count
//  FIRST_IN_ROW  0    1: no left neighbour; ops on dir L act as HOLD
//  LAST_IN_ROW   0    1: no right neighbour; ops on dir R act as HOLD
//  INIT_WORD     0    o_PE value after reset (W = ADDR_WIDTH+DATA_WIDTH bits)
// PORTS
//  clk        in   1          clock
//  rst        in   1          synchronous active-high reset
//  i_PE_l     in   W          left neighbour word
//  i_PE_r     in   W          right neighbour word
//  i_PE_u     in   W          up neighbour word
//  i_PE_d     in   W          down neighbour word
//  cmd_valid  in   1          command offered
//  cmd_ready  out  1          command accepted when valid&&ready at clk edge
//  cmd_op     in   2          00 HOLD, 01 SEL, 10 MIN, 11 MAX
//  cmd_dir    in   2          00 L, 01 R, 10 U, 11 D
//  cmd_cnt    in   CNT_WIDTH  op executes cmd_cnt+1 cycles
//  o_PE       out  W          registered local word {addr,data}
//  done       out  1          one-cycle pulse after final update of a command
//  swap_cnt   out  16         only with NANCI_PE_XCHG_STATS_EN
// BEHAVIOUR
//  Reset: o_PE=INIT_WORD, state IDLE, cmd_ready=1, done=0, latched cmd cleared, swap_cnt=0.
//  FSM IDLE/EXEC. IDLE: cmd_ready=1; handshake latches op/dir/cnt and moves to EXEC; o_PE unchanged at that edge.
//  EXEC: every edge applies the latched op to the neighbour word sampled at that edge.
//  The remaining count decrements each EXEC edge.
//  Accept at edge t -> o_PE updates at edges t+1 .. t+1+cnt; done=1 for the cycle after edge t+1+cnt.
//  cmd_ready=1 in the final EXEC cycle (remaining==0).
//  Handshake in that cycle: reload and stay in EXEC, back-to-back, no bubble; done still pulses for the finished cmd.
//  Otherwise EXEC -> IDLE after the final edge.
//  Ops: HOLD o_PE<=o_PE. SEL o_PE<=nbr.
//  MIN: o_PE<=nbr if nbr.addr < o_PE.addr, else unchanged. MAX: o_PE<=nbr if nbr.addr > o_PE.addr, else unchanged.
//  Compare is unsigned on the ADDR field only; ties keep the local word (stable); payload moves with its key.
//  dir L with FIRST_IN_ROW=1 or dir R with LAST_IN_ROW=1: forced HOLD, still consumes its cycles and pulses done.
//  cmd_cnt=0: single cycle. cmd_cnt all-ones: 2^CNT_WIDTH cycles, no wrap.
//  Reset mid-EXEC: command dropped, reset values next cycle, no done pulse.
//  cmd_valid in EXEC (non-final cycle): ignored; no accept until ready.
// CONFIGURATION
//  NANCI_PE_XCHG_STATS_EN defined:
//   - swap_cnt port present; +1 on each EXEC edge where MIN/MAX takes the neighbour word.
//   - saturates at 16'hFFFF; cleared by rst.
//  Undefined: swap_cnt port and its counter absent; all other behaviour identical.
// STRUCTURE
//  nanci_pkg: op encodings (OP_HOLD/SEL/MIN/MAX), dir encodings (DIR_L/R/U/D), FSM state encodings.
//  Sub-module nanci_word_cmp (combinational): inputs local word, neighbour word, op.
//  nanci_word_cmp outputs: next word and take_nbr flag. Parametrised by ADDR_WIDTH/DATA_WIDTH.
//  Top holds FSM, count register, neighbour mux, edge masking, output register.
// TESTING (ADDR_WIDTH=3, DATA_WIDTH=3, INIT_WORD=0)
//  1. l=001000 r=010000 u=011000 d=100000; SEL dir L cnt 0 -> o_PE=001000 one cycle after accept; done next cycle.
//  2. From o_PE=011101: MIN dir D (d=100000) -> 011101 kept.
//     Then MIN dir L (l=001000) -> 001000; swap_cnt=1 if STATS_EN.
//  3. Tie: o_PE=010111, MAX dir R, r=010000 -> o_PE stays 010111, no swap counted.
//  4. FIRST_IN_ROW=1: SEL dir L cnt 2 -> o_PE unchanged for 3 cycles; done pulses once.
//  5. SEL U cnt 3, valid held with SEL D in final cycle -> 4 updates to u then d, no gap; done pulses once per cmd.
//  6. rst during 2nd cycle of SEL R cnt 5 -> next cycle o_PE=000000, cmd_ready=1, done=0; no done afterward.

Source files
------------

// File: rtl/nanci_pkg.sv
// Shared encodings for the Nanci mesh PE neighbour-exchange core.
package nanci_pkg;

    localparam logic [1:0] OP_HOLD = 2'b00;
    localparam logic [1:0] OP_SEL  = 2'b01;
    localparam logic [1:0] OP_MIN  = 2'b10;
    localparam logic [1:0] OP_MAX  = 2'b11;

    localparam logic [1:0] DIR_L = 2'b00;
    localparam logic [1:0] DIR_R = 2'b01;
    localparam logic [1:0] DIR_U = 2'b10;
    localparam logic [1:0] DIR_D = 2'b11;

    localparam logic [0:0] ST_IDLE = 1'b0;
    localparam logic [0:0] ST_EXEC = 1'b1;

    typedef struct packed {
        logic [1:0] op;
        logic [1:0] dir;
    } cmd_sel_t;

endpackage

// File: rtl/nanci_pe_xchg_if.sv
// Command handshake bundle for nanci_pe_xchg: valid/ready plus op, direction and repeat count.
interface nanci_pe_xchg_if #(
    parameter int CNT_WIDTH = 4
);
    logic                 cmd_valid;
    logic                 cmd_ready;
    logic [1:0]           cmd_op;
    logic [1:0]           cmd_dir;
    logic [CNT_WIDTH-1:0] cmd_cnt;

    modport master (output cmd_valid, output cmd_op, output cmd_dir, output cmd_cnt, input cmd_ready);
    modport slave  (input cmd_valid, input cmd_op, input cmd_dir, input cmd_cnt, output cmd_ready);
endinterface

// File: rtl/nanci_word_cmp.sv
// Combinational next-word selection for one compare-exchange step on {addr,data} words.
module nanci_word_cmp
    import nanci_pkg::*;
#(
    parameter int ADDR_WIDTH = 3,
    parameter int DATA_WIDTH = 3
) (
    input  logic [ADDR_WIDTH+DATA_WIDTH-1:0] i_local,
    input  logic [ADDR_WIDTH+DATA_WIDTH-1:0] i_nbr,
    input  logic [1:0]                       i_op,
    output logic [ADDR_WIDTH+DATA_WIDTH-1:0] o_next,
    output logic                             o_take_nbr
);
    localparam int W = ADDR_WIDTH + DATA_WIDTH;

    logic [ADDR_WIDTH-1:0] w_loc_addr;
    logic [ADDR_WIDTH-1:0] w_nbr_addr;

    assign w_loc_addr = i_local[W-1 -: ADDR_WIDTH];
    assign w_nbr_addr = i_nbr[W-1 -: ADDR_WIDTH];

    // Ties keep the local word so repeated sort steps stay stable.
    always_comb begin
        o_next     = i_local;
        o_take_nbr = 1'b0;
        case (i_op)
            OP_SEL: o_next = i_nbr;
            OP_MIN: begin
                if (w_nbr_addr < w_loc_addr) begin
                    o_next     = i_nbr;
                    o_take_nbr = 1'b1;
                end
            end
            OP_MAX: begin
                if (w_nbr_addr > w_loc_addr) begin
                    o_next     = i_nbr;
                    o_take_nbr = 1'b1;
                end
            end
            default: ;
        endcase
    end
endmodule

// File: rtl/nanci_pe_xchg.sv
// Nanci mesh PE neighbour-exchange core: queued HOLD/SEL/MIN/MAX commands with repeat counts.
// Optional swap statistics counter enabled by defining NANCI_PE_XCHG_STATS_EN.
module nanci_pe_xchg
    import nanci_pkg::*;
#(
    parameter int ADDR_WIDTH   = 3,
    parameter int DATA_WIDTH   = 3,
    parameter int CNT_WIDTH    = 4,
    parameter bit FIRST_IN_ROW = 1'b0,
    parameter bit LAST_IN_ROW  = 1'b0,
    parameter logic [ADDR_WIDTH+DATA_WIDTH-1:0] INIT_WORD = '0
) (
    input  logic                             clk,
    input  logic                             rst,
    input  logic [ADDR_WIDTH+DATA_WIDTH-1:0] i_PE_l,
    input  logic [ADDR_WIDTH+DATA_WIDTH-1:0] i_PE_r,
    input  logic [ADDR_WIDTH+DATA_WIDTH-1:0] i_PE_u,
    input  logic [ADDR_WIDTH+DATA_WIDTH-1:0] i_PE_d,
    nanci_pe_xchg_if.slave                   cmd,
    output logic [ADDR_WIDTH+DATA_WIDTH-1:0] o_PE,
    output logic                             done
`ifdef NANCI_PE_XCHG_STATS_EN
    ,
    output logic [15:0]                      swap_cnt
`endif
);
    localparam int W = ADDR_WIDTH + DATA_WIDTH;

    logic [0:0]           r_state;
    cmd_sel_t             r_cmd;
    logic [CNT_WIDTH-1:0] r_rem;
    logic [W-1:0]         r_word;
    logic                 r_done;

    logic                 w_exec;
    logic                 w_last;
    logic                 w_ready;
    logic                 w_accept;
    logic                 w_masked;
    logic [1:0]           w_op;
    logic [W-1:0]         w_nbr;
    logic [W-1:0]         w_next;
    logic                 w_take;

    assign w_exec   = (r_state == ST_EXEC);
    assign w_last   = w_exec && (r_rem == '0);
    assign w_ready  = (r_state == ST_IDLE) || (r_rem == '0);
    assign w_accept = cmd.cmd_valid && w_ready;

    always_comb begin
        w_nbr = i_PE_l;
        case (r_cmd.dir)
            DIR_L:   w_nbr = i_PE_l;
            DIR_R:   w_nbr = i_PE_r;
            DIR_U:   w_nbr = i_PE_u;
            DIR_D:   w_nbr = i_PE_d;
            default: w_nbr = i_PE_l;
        endcase
    end

    // Row-edge PEs have no neighbour on that side; the step still runs its cycles as a HOLD.
    assign w_masked = ((r_cmd.dir == DIR_L) && FIRST_IN_ROW) ||
                      ((r_cmd.dir == DIR_R) && LAST_IN_ROW);
    assign w_op     = w_masked ? OP_HOLD : r_cmd.op;

    nanci_word_cmp #(
        .ADDR_WIDTH (ADDR_WIDTH),
        .DATA_WIDTH (DATA_WIDTH)
    ) u_cmp (
        .i_local    (r_word),
        .i_nbr      (w_nbr),
        .i_op       (w_op),
        .o_next     (w_next),
        .o_take_nbr (w_take)
    );

    // A handshake in the final EXEC cycle reloads directly, so back-to-back commands have no bubble.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= ST_IDLE;
            r_cmd   <= '0;
            r_rem   <= '0;
            r_word  <= INIT_WORD;
            r_done  <= 1'b0;
        end else begin
            r_done <= w_last;
            if (w_exec) begin
                r_word <= w_next;
            end
            if (w_accept) begin
                r_cmd   <= '{op: cmd.cmd_op, dir: cmd.cmd_dir};
                r_rem   <= cmd.cmd_cnt;
                r_state <= ST_EXEC;
            end else if (w_last) begin
                r_state <= ST_IDLE;
            end else if (w_exec) begin
                r_rem <= r_rem - {{(CNT_WIDTH-1){1'b0}}, 1'b1};
            end
        end
    end

    assign cmd.cmd_ready = w_ready;
    assign o_PE          = r_word;
    assign done          = r_done;

`ifdef NANCI_PE_XCHG_STATS_EN
    logic [15:0] r_swap;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_swap <= '0;
        end else if (w_exec && w_take && (r_swap != 16'hFFFF)) begin
            r_swap <= r_swap + 16'd1;
        end
    end

    assign swap_cnt = r_swap;
`else
    logic w_take_unused;
    assign w_take_unused = w_take;
`endif
endmodule

// File: tb/tb_nanci_pe_xchg.sv
// Bench for nanci_pe_xchg: table of chained commands with a done-driven scoreboard plus hand sequences.
module tb_nanci_pe_xchg;
    import nanci_pkg::*;

    localparam int W = 6;

    logic         clk = 1'b0;
    logic         rst;
    logic [W-1:0] l, r, u, d;
    logic [W-1:0] pe0, pe1;
    logic         done0, done1;
`ifdef NANCI_PE_XCHG_STATS_EN
    logic [15:0]  sw0, sw1;
`endif

    always #5 clk = ~clk;

    nanci_pe_xchg_if #(.CNT_WIDTH(4)) c0 ();
    nanci_pe_xchg_if #(.CNT_WIDTH(4)) c1 ();

    nanci_pe_xchg #(
        .ADDR_WIDTH(3), .DATA_WIDTH(3), .CNT_WIDTH(4),
        .FIRST_IN_ROW(1'b0), .LAST_IN_ROW(1'b0), .INIT_WORD(6'b000000)
    ) dut0 (
        .clk(clk), .rst(rst),
        .i_PE_l(l), .i_PE_r(r), .i_PE_u(u), .i_PE_d(d),
        .cmd(c0), .o_PE(pe0), .done(done0)
`ifdef NANCI_PE_XCHG_STATS_EN
        , .swap_cnt(sw0)
`endif
    );

    nanci_pe_xchg #(
        .ADDR_WIDTH(3), .DATA_WIDTH(3), .CNT_WIDTH(4),
        .FIRST_IN_ROW(1'b1), .LAST_IN_ROW(1'b1), .INIT_WORD(6'b101010)
    ) dut1 (
        .clk(clk), .rst(rst),
        .i_PE_l(l), .i_PE_r(r), .i_PE_u(u), .i_PE_d(d),
        .cmd(c1), .o_PE(pe1), .done(done1)
`ifdef NANCI_PE_XCHG_STATS_EN
        , .swap_cnt(sw1)
`endif
    );

    typedef struct {
        logic [W-1:0] l, r, u, d;
        logic [1:0]   op, dir;
        logic [3:0]   cnt;
        logic [W-1:0] exp;
        int           swp;
    } vec_t;

    vec_t         vt[13];
    logic [W-1:0] exp_q[$];
    int           n_vec = 0;
    int           n_bad = 0;
    int           exp_swaps = 0;

    function automatic vec_t mk(input logic [W-1:0] vl, vr, vu, vd, input logic [1:0] op, dir,
                                input logic [3:0] cnt, input logic [W-1:0] exp, input int swp);
        vec_t v;
        v.l = vl; v.r = vr; v.u = vu; v.d = vd;
        v.op = op; v.dir = dir; v.cnt = cnt; v.exp = exp; v.swp = swp;
        return v;
    endfunction

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] want);
        n_vec++;
        if (act !== want) begin
            n_bad++;
            $display("FAIL %s: got %0h, required %0h", nm, act, want);
        end
    endtask

    task automatic run_vec(input vec_t v, input int idx);
        int           lat;
        logic [W-1:0] ew;
        l = v.l; r = v.r; u = v.u; d = v.d;
        c0.cmd_op = v.op; c0.cmd_dir = v.dir; c0.cmd_cnt = v.cnt; c0.cmd_valid = 1'b1;
        chk($sformatf("v%0d ready", idx), 32'(c0.cmd_ready), 32'(1));
        @(posedge clk);
        @(negedge clk);
        c0.cmd_valid = 1'b0;
        exp_q.push_back(v.exp);
        lat = -1;
        for (int k = 0; k < 40; k++) begin
            if (done0) begin
                lat = k;
                break;
            end
            @(negedge clk);
        end
        chk($sformatf("v%0d done latency", idx), 32'(lat), 32'(int'(v.cnt) + 1));
        ew = exp_q.pop_front();
        chk($sformatf("v%0d o_PE", idx), 32'(pe0), 32'(ew));
        exp_swaps += v.swp;
`ifdef NANCI_PE_XCHG_STATS_EN
        chk($sformatf("v%0d swap_cnt", idx), 32'(sw0), 32'(exp_swaps));
`endif
        @(negedge clk);
        chk($sformatf("v%0d done single", idx), 32'(done0), 32'(0));
    endtask

    task automatic run1(input string nm, input logic [1:0] op, dir, input logic [3:0] cnt,
                        input logic [W-1:0] exp);
        c1.cmd_op = op; c1.cmd_dir = dir; c1.cmd_cnt = cnt; c1.cmd_valid = 1'b1;
        @(posedge clk);
        @(negedge clk);
        c1.cmd_valid = 1'b0;
        for (int k = 1; k <= int'(cnt) + 2; k++) begin
            @(negedge clk);
            chk($sformatf("%s k%0d o_PE", nm, k), 32'(pe1), 32'(exp));
            chk($sformatf("%s k%0d done", nm, k), 32'(done1), 32'(k == int'(cnt) + 1));
        end
    endtask

    initial begin
        logic [W-1:0] e_pe[7];
        logic         e_dn[7];
        logic         e_rd[7];
        int           nd;

        rst = 1'b1;
        l = '0; r = '0; u = '0; d = '0;
        c0.cmd_valid = 1'b0; c0.cmd_op = OP_HOLD; c0.cmd_dir = DIR_L; c0.cmd_cnt = '0;
        c1.cmd_valid = 1'b0; c1.cmd_op = OP_HOLD; c1.cmd_dir = DIR_L; c1.cmd_cnt = '0;
        repeat (3) @(negedge clk);
        chk("rst o_PE", 32'(pe0), 32'(6'b000000));
        chk("rst ready", 32'(c0.cmd_ready), 32'(1));
        chk("rst done", 32'(done0), 32'(0));
        chk("rst o_PE edge", 32'(pe1), 32'(6'b101010));
`ifdef NANCI_PE_XCHG_STATS_EN
        chk("rst swap_cnt", 32'(sw0), 32'(0));
`endif
        rst = 1'b0;

        vt[0]  = mk(6'o10, 6'o20, 6'o30, 6'o40, OP_SEL,  DIR_L, 4'd0,  6'b001000, 0);
        vt[1]  = mk(6'o10, 6'o20, 6'b011101, 6'o40, OP_SEL, DIR_U, 4'd1, 6'b011101, 0);
        vt[2]  = mk(6'o10, 6'o20, 6'b011101, 6'b100000, OP_MIN, DIR_D, 4'd0, 6'b011101, 0);
        vt[3]  = mk(6'b001000, 6'o20, 6'o30, 6'o40, OP_MIN, DIR_L, 4'd0, 6'b001000, 1);
        vt[4]  = mk(6'o10, 6'b010111, 6'o30, 6'o40, OP_SEL, DIR_R, 4'd0, 6'b010111, 0);
        vt[5]  = mk(6'o10, 6'b010000, 6'o30, 6'o40, OP_MAX, DIR_R, 4'd0, 6'b010111, 0);
        vt[6]  = mk(6'o10, 6'o20, 6'b111010, 6'o40, OP_MAX, DIR_U, 4'd2, 6'b111010, 1);
        vt[7]  = mk(6'o10, 6'o20, 6'o30, 6'b000001, OP_MIN, DIR_D, 4'd0, 6'b000001, 1);
        vt[8]  = mk(6'b000111, 6'o20, 6'o30, 6'o40, OP_MAX, DIR_L, 4'd0, 6'b000001, 0);
        vt[9]  = mk(6'o10, 6'o20, 6'b101010, 6'o40, OP_HOLD, DIR_U, 4'd3, 6'b000001, 0);
        vt[10] = mk(6'o10, 6'o20, 6'o30, 6'b110011, OP_SEL, DIR_D, 4'd15, 6'b110011, 0);
        vt[11] = mk(6'o10, 6'o20, 6'b101100, 6'o40, OP_MIN, DIR_U, 4'd0, 6'b101100, 1);
        vt[12] = mk(6'b111111, 6'o20, 6'o30, 6'o40, OP_MAX, DIR_L, 4'd0, 6'b111111, 1);

        for (int i = 0; i < 13; i++) run_vec(vt[i], i);

        // Back-to-back: SEL U x4 then SEL D offered throughout, accepted only in the final cycle.
        u = 6'b001001; d = 6'b010010;
        c0.cmd_op = OP_SEL; c0.cmd_dir = DIR_U; c0.cmd_cnt = 4'd3; c0.cmd_valid = 1'b1;
        @(posedge clk);
        @(negedge clk);
        c0.cmd_dir = DIR_D; c0.cmd_cnt = 4'd0;
        e_pe = '{6'b111111, 6'b001001, 6'b001001, 6'b001001, 6'b001001, 6'b010010, 6'b010010};
        e_dn = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0};
        e_rd = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 1'b1};
        for (int k = 0; k < 7; k++) begin
            chk($sformatf("b2b k%0d o_PE", k), 32'(pe0), 32'(e_pe[k]));
            chk($sformatf("b2b k%0d done", k), 32'(done0), 32'(e_dn[k]));
            chk($sformatf("b2b k%0d ready", k), 32'(c0.cmd_ready), 32'(e_rd[k]));
            if (k == 4) c0.cmd_valid = 1'b0;
            @(negedge clk);
        end

        // Row-edge masking on the second instance.
        l = 6'b001000; r = 6'b011011;
        run1("edge L", OP_SEL, DIR_L, 4'd2, 6'b101010);
        run1("edge U", OP_SEL, DIR_U, 4'd0, 6'b001001);
        run1("edge R", OP_MAX, DIR_R, 4'd1, 6'b001001);

        // Reset during the second cycle of a long command.
        r = 6'b011011;
        c0.cmd_op = OP_SEL; c0.cmd_dir = DIR_R; c0.cmd_cnt = 4'd5; c0.cmd_valid = 1'b1;
        @(posedge clk);
        @(negedge clk);
        c0.cmd_valid = 1'b0;
        chk("rstmid k0 o_PE", 32'(pe0), 32'(6'b010010));
        @(negedge clk);
        chk("rstmid k1 o_PE", 32'(pe0), 32'(6'b011011));
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        chk("rstmid o_PE", 32'(pe0), 32'(6'b000000));
        chk("rstmid ready", 32'(c0.cmd_ready), 32'(1));
        chk("rstmid done", 32'(done0), 32'(0));
`ifdef NANCI_PE_XCHG_STATS_EN
        chk("rstmid swap_cnt", 32'(sw0), 32'(0));
`endif
        nd = 0;
        for (int k = 0; k < 10; k++) begin
            @(negedge clk);
            if (done0) nd++;
        end
        chk("rstmid no done", 32'(nd), 32'(0));
        chk("rstmid o_PE held", 32'(pe0), 32'(6'b000000));

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end
endmodule
